// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: hazard and sequencing controller for the 5-stage core.
// Detects load-use hazards and inserts bubbles, redirects fetch on a taken
// branch (MEM) or a jump (EX), freezes the pipeline while data memory is
// busy, drives the EX-stage forwarding selects and keeps saturating event
// counters.
// Ports:
//   clk, rst (synchronous, active-low)
//   mem_busy, clr_cnt                    - freeze request, counter clear
//   FD_*, DX_*, XM_*, MW_*               - register ids / controls per stage
//   JT, XM_BT                            - jump / branch redirect targets
//   PC_write, FD_write, DX_write, XM_write  - pipeline register enables
//   FD_flush, DX_flush, XM_flush         - bubble insertion
//   PC_sel, PC_target                    - next-PC select and target
//   fwd_A, fwd_B                         - ALU operand forwarding selects
//   stall_cnt, flush_cnt                 - saturating event counters
module ex_hazard_ctrl #(
    parameter int unsigned LU_STALL = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_busy,
    input  logic             clr_cnt,
    input  logic [4:0]       FD_rs,
    input  logic [4:0]       FD_rt,
    input  logic             FD_use_rt,
    input  logic [4:0]       DX_rs,
    input  logic [4:0]       DX_rt,
    input  logic [4:0]       DX_RD,
    input  logic             DX_MemRead,
    input  logic             DX_jump,
    input  logic [31:0]      JT,
    input  logic             XM_branch,
    input  logic [31:0]      XM_BT,
    input  logic [4:0]       XM_RD,
    input  logic             XM_RegWrite,
    input  logic [4:0]       MW_RD,
    input  logic             MW_RegWrite,
    output logic             PC_write,
    output logic             FD_write,
    output logic             DX_write,
    output logic             XM_write,
    output logic             FD_flush,
    output logic             DX_flush,
    output logic             XM_flush,
    output logic [1:0]       PC_sel,
    output logic [31:0]      PC_target,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned SL_W = 3;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SL_W-1:0]   stall_left_q, stall_left_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              stall_inc;
    logic              flush_inc;
    logic              lu_hz;

    // Load in EX writing a register the ID instruction reads.
    assign lu_hz = DX_MemRead && (DX_RD != 5'd0) &&
                   ((DX_RD == FD_rs) || (FD_use_rt && (DX_RD == FD_rt)));

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= RUN;
            stall_left_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Next-state and pipeline control, in priority order.
    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        PC_write     = 1'b1;
        FD_write     = 1'b1;
        DX_write     = 1'b1;
        XM_write     = 1'b1;
        FD_flush     = 1'b0;
        DX_flush     = 1'b0;
        XM_flush     = 1'b0;
        PC_sel       = PC_SEL_SEQ;
        PC_target    = 32'd0;

        if (!rst) begin
            PC_write = 1'b0;
            FD_write = 1'b0;
            DX_write = 1'b0;
            XM_write = 1'b0;
            FD_flush = 1'b1;
            DX_flush = 1'b1;
            XM_flush = 1'b1;
        end else if (mem_busy) begin
            // Whole pipeline holds; a pending redirect waits for release.
            PC_write = 1'b0;
            FD_write = 1'b0;
            DX_write = 1'b0;
            XM_write = 1'b0;
        end else if (XM_branch) begin
            // Oldest redirect wins; younger jump/hazard are squashed.
            PC_sel       = PC_SEL_BR;
            PC_target    = XM_BT;
            FD_flush     = 1'b1;
            DX_flush     = 1'b1;
            XM_flush     = 1'b1;
            state_d      = RUN;
            stall_left_d = '0;
            flush_inc    = 1'b1;
        end else if (DX_jump) begin
            PC_sel       = PC_SEL_JMP;
            PC_target    = JT;
            FD_flush     = 1'b1;
            DX_flush     = 1'b1;
            state_d      = RUN;
            stall_left_d = '0;
            flush_inc    = 1'b1;
        end else if ((state_q == STALL) || lu_hz) begin
            // Hold PC and IF/ID, push a bubble into EX.
            PC_write  = 1'b0;
            FD_write  = 1'b0;
            DX_flush  = 1'b1;
            stall_inc = 1'b1;
            if (state_q == RUN) begin
                if (LU_STALL > 1) begin
                    state_d      = STALL;
                    stall_left_d = SL_W'(LU_STALL - 1);
                end
            end else begin
                stall_left_d = stall_left_q - SL_W'(1);
                if (stall_left_q == SL_W'(1)) begin
                    state_d = RUN;
                end
            end
        end
    end

    // Saturating counters; clear beats increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Operand forwarding; MEM result is newer than WB so it wins.
    always_comb begin
        fwd_A = FWD_RF;
        fwd_B = FWD_RF;
        if (rst) begin
            if (XM_RegWrite && (XM_RD != 5'd0) && (XM_RD == DX_rs)) begin
                fwd_A = FWD_MEM;
            end else if (MW_RegWrite && (MW_RD != 5'd0) && (MW_RD == DX_rs)) begin
                fwd_A = FWD_WB;
            end
            if (XM_RegWrite && (XM_RD != 5'd0) && (XM_RD == DX_rt)) begin
                fwd_B = FWD_MEM;
            end else if (MW_RegWrite && (MW_RD != 5'd0) && (MW_RD == DX_rt)) begin
                fwd_B = FWD_WB;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench: d1 uses a single-cycle load-use stall with 16-bit counters,
// d3 uses a three-cycle stall with 3-bit counters so saturation is reachable.
module tb_ex_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, mem_busy, clr_cnt;
    logic [4:0]  FD_rs, FD_rt, DX_rs, DX_rt, DX_RD, XM_RD, MW_RD;
    logic        FD_use_rt, DX_MemRead, DX_jump, XM_branch, XM_RegWrite, MW_RegWrite;
    logic [31:0] JT, XM_BT;

    logic        a_pcw, a_fdw, a_dxw, a_xmw, a_fdf, a_dxf, a_xmf;
    logic [1:0]  a_sel, a_fa, a_fb;
    logic [31:0] a_tgt;
    logic [15:0] a_sc, a_fc;

    logic        b_pcw, b_fdw, b_dxw, b_xmw, b_fdf, b_dxf, b_xmf;
    logic [1:0]  b_sel, b_fa, b_fb;
    logic [31:0] b_tgt;
    logic [2:0]  b_sc, b_fc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.LU_STALL(1), .CNT_W(16)) d1 (
        .clk(clk), .rst(rst), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .FD_rs(FD_rs), .FD_rt(FD_rt), .FD_use_rt(FD_use_rt),
        .DX_rs(DX_rs), .DX_rt(DX_rt), .DX_RD(DX_RD), .DX_MemRead(DX_MemRead),
        .DX_jump(DX_jump), .JT(JT), .XM_branch(XM_branch), .XM_BT(XM_BT),
        .XM_RD(XM_RD), .XM_RegWrite(XM_RegWrite), .MW_RD(MW_RD), .MW_RegWrite(MW_RegWrite),
        .PC_write(a_pcw), .FD_write(a_fdw), .DX_write(a_dxw), .XM_write(a_xmw),
        .FD_flush(a_fdf), .DX_flush(a_dxf), .XM_flush(a_xmf),
        .PC_sel(a_sel), .PC_target(a_tgt), .fwd_A(a_fa), .fwd_B(a_fb),
        .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    ex_hazard_ctrl #(.LU_STALL(3), .CNT_W(3)) d3 (
        .clk(clk), .rst(rst), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .FD_rs(FD_rs), .FD_rt(FD_rt), .FD_use_rt(FD_use_rt),
        .DX_rs(DX_rs), .DX_rt(DX_rt), .DX_RD(DX_RD), .DX_MemRead(DX_MemRead),
        .DX_jump(DX_jump), .JT(JT), .XM_branch(XM_branch), .XM_BT(XM_BT),
        .XM_RD(XM_RD), .XM_RegWrite(XM_RegWrite), .MW_RD(MW_RD), .MW_RegWrite(MW_RegWrite),
        .PC_write(b_pcw), .FD_write(b_fdw), .DX_write(b_dxw), .XM_write(b_xmw),
        .FD_flush(b_fdf), .DX_flush(b_dxf), .XM_flush(b_xmf),
        .PC_sel(b_sel), .PC_target(b_tgt), .fwd_A(b_fa), .fwd_B(b_fb),
        .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; mem_busy = 1'b0; clr_cnt = 1'b0;
        FD_rs = '0; FD_rt = '0; FD_use_rt = 1'b0;
        DX_rs = '0; DX_rt = '0; DX_RD = '0; DX_MemRead = 1'b0; DX_jump = 1'b0;
        JT = '0; XM_branch = 1'b0; XM_BT = '0;
        XM_RD = '0; XM_RegWrite = 1'b0; MW_RD = '0; MW_RegWrite = 1'b0;

        // Reset held for two cycles.
        step(); step(); #1;
        chk("rst_pcw", 32'(a_pcw), 32'd0);
        chk("rst_xmw", 32'(a_xmw), 32'd0);
        chk("rst_fdf", 32'(a_fdf), 32'd1);
        chk("rst_dxf", 32'(a_dxf), 32'd1);
        chk("rst_xmf", 32'(a_xmf), 32'd1);
        chk("rst_sc", 32'(a_sc), 32'd0);

        rst = 1'b1; #1;
        chk("run_pcw", 32'(a_pcw), 32'd1);
        chk("run_fdw", 32'(a_fdw), 32'd1);
        chk("run_dxw", 32'(a_dxw), 32'd1);
        chk("run_xmw", 32'(a_xmw), 32'd1);
        chk("run_sel", 32'(a_sel), 32'd0);
        chk("run_tgt", a_tgt, 32'd0);
        chk("run_dxf", 32'(a_dxf), 32'd0);
        chk("run_fc", 32'(a_fc), 32'd0);

        // Load-use hazard for one cycle.
        DX_MemRead = 1'b1; DX_RD = 5'd5; FD_rs = 5'd5; #1;
        chk("lu1_pcw", 32'(a_pcw), 32'd0);
        chk("lu1_fdw", 32'(a_fdw), 32'd0);
        chk("lu1_dxf", 32'(a_dxf), 32'd1);
        chk("lu1_dxw", 32'(a_dxw), 32'd1);
        chk("lu3_c0_pcw", 32'(b_pcw), 32'd0);
        step();
        DX_MemRead = 1'b0; #1;
        chk("lu1_done_pcw", 32'(a_pcw), 32'd1);
        chk("lu1_sc", 32'(a_sc), 32'd1);
        chk("lu3_c1_pcw", 32'(b_pcw), 32'd0);
        chk("lu3_c1_fdw", 32'(b_fdw), 32'd0);
        chk("lu3_c1_dxf", 32'(b_dxf), 32'd1);
        step();
        chk("lu3_c2_pcw", 32'(b_pcw), 32'd0);
        chk("lu3_c2_sc", 32'(b_sc), 32'd2);
        step();
        chk("lu3_done_pcw", 32'(b_pcw), 32'd1);
        chk("lu3_sc", 32'(b_sc), 32'd3);

        // Load to r0 is never a hazard.
        DX_MemRead = 1'b1; DX_RD = 5'd0; FD_rs = 5'd0; #1;
        chk("r0_pcw", 32'(a_pcw), 32'd1);
        chk("r0_dxf", 32'(b_dxf), 32'd0);
        step();
        chk("r0_sc", 32'(a_sc), 32'd1);

        // rt match only counts when the ID instruction reads rt.
        DX_RD = 5'd6; FD_rt = 5'd6; FD_rs = 5'd1; FD_use_rt = 1'b0; #1;
        chk("rt_unused_pcw", 32'(a_pcw), 32'd1);
        FD_use_rt = 1'b1; #1;
        chk("rt_used_pcw", 32'(a_pcw), 32'd0);
        DX_MemRead = 1'b0; FD_use_rt = 1'b0; FD_rt = '0; #1;

        // Hazard then branch in the second stall cycle of d3.
        DX_MemRead = 1'b1; DX_RD = 5'd5; FD_rs = 5'd5; #1;
        step();
        DX_MemRead = 1'b0; XM_branch = 1'b1; XM_BT = 32'h40; #1;
        chk("br_sel", 32'(b_sel), 32'd1);
        chk("br_tgt", b_tgt, 32'h40);
        chk("br_pcw", 32'(b_pcw), 32'd1);
        chk("br_fdf", 32'(b_fdf), 32'd1);
        chk("br_dxf", 32'(b_dxf), 32'd1);
        chk("br_xmf", 32'(b_xmf), 32'd1);
        step();
        XM_branch = 1'b0; #1;
        chk("br_after_pcw", 32'(b_pcw), 32'd1);
        chk("br_after_dxf", 32'(b_dxf), 32'd0);
        chk("br_fc", 32'(b_fc), 32'd1);
        chk("br_sc3", 32'(b_sc), 32'd4);
        chk("br_sc1", 32'(a_sc), 32'd2);

        // Branch and jump together: branch wins.
        XM_branch = 1'b1; XM_BT = 32'h100; DX_jump = 1'b1; JT = 32'h200; #1;
        chk("both_sel", 32'(a_sel), 32'd1);
        chk("both_tgt", a_tgt, 32'h100);
        step();
        XM_branch = 1'b0; #1;
        chk("both_fc", 32'(a_fc), 32'd2);
        chk("jmp_sel", 32'(a_sel), 32'd2);
        chk("jmp_tgt", a_tgt, 32'h200);
        chk("jmp_dxf", 32'(a_dxf), 32'd1);
        chk("jmp_xmf", 32'(a_xmf), 32'd0);
        step();
        DX_jump = 1'b0; #1;
        chk("jmp_fc", 32'(a_fc), 32'd3);

        // Freeze with a pending branch.
        mem_busy = 1'b1; XM_branch = 1'b1; XM_BT = 32'h80;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("frz_pcw", 32'(a_pcw), 32'd0);
            chk("frz_xmw", 32'(a_xmw), 32'd0);
            chk("frz_fdf", 32'(a_fdf), 32'd0);
            chk("frz_xmf", 32'(b_xmf), 32'd0);
            step();
        end
        chk("frz_fc", 32'(a_fc), 32'd3);
        mem_busy = 1'b0; #1;
        chk("frz_rel_sel", 32'(a_sel), 32'd1);
        chk("frz_rel_tgt", a_tgt, 32'h80);
        step();
        XM_branch = 1'b0; #1;
        chk("frz_rel_fc", 32'(a_fc), 32'd4);
        chk("frz_rel_pcw", 32'(a_pcw), 32'd1);

        // Forwarding.
        XM_RD = 5'd7; MW_RD = 5'd7; DX_rs = 5'd7; DX_rt = 5'd7;
        XM_RegWrite = 1'b1; MW_RegWrite = 1'b1; #1;
        chk("fwdA_mem", 32'(a_fa), 32'd2);
        chk("fwdB_mem", 32'(a_fb), 32'd2);
        XM_RegWrite = 1'b0; #1;
        chk("fwdA_wb", 32'(a_fa), 32'd1);
        DX_rs = 5'd0; #1;
        chk("fwdA_rf", 32'(a_fa), 32'd0);
        chk("fwdB_wb", 32'(a_fb), 32'd1);
        mem_busy = 1'b1; #1;
        chk("fwdB_frz", 32'(b_fb), 32'd1);
        mem_busy = 1'b0; MW_RegWrite = 1'b0; #1;

        // Ten back-to-back stall cycles: d3 saturates at 7.
        DX_MemRead = 1'b1; DX_RD = 5'd5; FD_rs = 5'd5;
        repeat (10) step();
        chk("sat_sc3", 32'(b_sc), 32'd7);
        chk("sat_sc1", 32'(a_sc), 32'd12);
        step();
        chk("sat_hold_sc3", 32'(b_sc), 32'd7);

        // Clear beats a same-cycle increment.
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0; DX_MemRead = 1'b0; #1;
        chk("clr_sc1", 32'(a_sc), 32'd0);
        chk("clr_sc3", 32'(b_sc), 32'd0);
        chk("clr_fc1", 32'(a_fc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core. It sits beside the ID/EX/MEM stages and gates the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- It detects load-use hazards and inserts stall bubbles, and it redirects fetch on a taken branch (XM stage) or a jump (DX stage), squashing the younger instructions.
- It freezes the whole pipeline while data memory is busy, drives the EX-stage ALU operand forwarding selects, and keeps saturating stall and flush event counters.

Parameters:
LU_STALL, 1, bubble cycles inserted per load-use hazard (legal range 1..7)
CNT_W, 16, width of each event counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-low reset, sampled at posedge clk
mem_busy  in  1  data memory not ready; freezes the pipeline
clr_cnt  in  1  synchronous clear of both counters
FD_rs  in  5  rs of the instruction in ID
FD_rt  in  5  rt of the instruction in ID
FD_use_rt  in  1  ID instruction reads rt
DX_rs  in  5  rs of the instruction in EX
DX_rt  in  5  rt of the instruction in EX
DX_RD  in  5  destination register in EX
DX_MemRead  in  1  EX instruction is a load
DX_jump  in  1  EX instruction is a jump
JT  in  32  jump target
XM_branch  in  1  taken branch resolved, valid in MEM
XM_BT  in  32  branch target
XM_RD  in  5  destination register in MEM
XM_RegWrite  in  1  MEM instruction writes the register file
MW_RD  in  5  destination register in WB
MW_RegWrite  in  1  WB instruction writes the register file
PC_write  out  1  PC register enable
FD_write  out  1  IF/ID register enable
DX_write  out  1  ID/EX register enable
XM_write  out  1  EX/MEM register enable
FD_flush  out  1  load a bubble into IF/ID
DX_flush  out  1  load a bubble into ID/EX
XM_flush  out  1  load a bubble into EX/MEM
PC_sel  out  2  next-PC select: 00 = PC+4, 01 = XM_BT, 10 = JT
PC_target  out  32  selected redirect target; 0 when PC_sel = 00
fwd_A  out  2  ALU operand A source: 00 = register file, 01 = WB, 10 = MEM
fwd_B  out  2  ALU operand B source, same encoding as fwd_A
stall_cnt  out  CNT_W  count of load-use stall cycles
flush_cnt  out  CNT_W  count of redirect events

Behaviour:
- State: FSM {RUN, STALL}, 3-bit stall_left down-counter, stall_cnt, flush_cnt. All registered; all other outputs are combinational from state and inputs.
- Reset (rst = 0 at posedge): state becomes RUN; stall_left, stall_cnt and flush_cnt become 0.
- While rst = 0: PC_write, FD_write, DX_write and XM_write are 0; all three flush outputs are 1; PC_sel = 00; fwd_A = fwd_B = 00.
- Default in RUN with no event: all write enables 1, all flushes 0, PC_sel = 00, PC_target = 0.
- Hazard detection (lu_hz) = DX_MemRead && DX_RD != 0 && (DX_RD == FD_rs || (FD_use_rt && DX_RD == FD_rt)).
- Priority, highest first:
  1. Freeze: mem_busy = 1 sets all write enables to 0 and all flushes to 0. State, stall_left and counters hold. A pending redirect is taken on the first cycle after mem_busy drops.
  2. Branch: XM_branch = 1 gives PC_sel = 01, PC_target = XM_BT, FD_flush = DX_flush = XM_flush = 1, PC_write = 1. Next state is RUN, stall_left is cleared, flush_cnt increments. A simultaneous DX_jump or lu_hz is ignored because those instructions are younger.
  3. Jump: DX_jump = 1 gives PC_sel = 10, PC_target = JT, FD_flush = DX_flush = 1, XM_flush = 0. Next state is RUN, flush_cnt increments, and any lu_hz is ignored.
  4. Load-use stall: applies when in RUN with lu_hz, or in STALL. Outputs are PC_write = 0, FD_write = 0, DX_flush = 1; DX_write and XM_write stay 1. stall_cnt increments.
     - On entry from RUN: if LU_STALL = 1, stay in RUN. Otherwise go to STALL with stall_left = LU_STALL - 1.
     - In STALL: decrement stall_left; move to RUN after the cycle in which stall_left = 1.
- Forwarding, evaluated for fwd_A against DX_rs and fwd_B against DX_rt:
  - 10 if XM_RegWrite && XM_RD != 0 && XM_RD matches.
  - Otherwise 01 if MW_RegWrite && MW_RD != 0 && MW_RD matches.
  - Otherwise 00. MEM has priority over WB.
  - Forwarding is independent of freeze and stall.
- Counters: saturate at all-ones and never wrap. clr_cnt = 1 clears both to 0 on the next edge and takes priority over an increment in the same cycle.

Test Plan:
- Reset: hold rst = 0 for 2 cycles → PC_write = 0, FD_flush = DX_flush = XM_flush = 1. Release rst → next cycle all write enables 1, counters 0, PC_sel = 00.
- Load-use, LU_STALL = 1: DX_MemRead = 1, DX_RD = 5, FD_rs = 5 for 1 cycle → exactly 1 cycle with PC_write = 0, FD_write = 0, DX_flush = 1; stall_cnt = 1. Repeat with DX_RD = 0 → no stall.
- LU_STALL = 3 with the same hazard → 3 consecutive stall cycles, stall_cnt = 3. Assert XM_branch (XM_BT = 0x40) in the 2nd stall cycle → redirect that cycle with PC_target = 0x40 and 3 flushes; next cycle RUN with no stall; flush_cnt = 1.
- Simultaneous events: XM_branch = 1 (XM_BT = 0x100) and DX_jump = 1 (JT = 0x200) together → PC_sel = 01, PC_target = 0x100, flush_cnt increments by exactly 1.
- Freeze: mem_busy = 1 for 4 cycles while XM_branch = 1 → all enables and flushes 0, no counter change. mem_busy drops → one redirect cycle to XM_BT.
- Forwarding: XM_RD = MW_RD = DX_rs = 7, both RegWrite = 1 → fwd_A = 10. Clear XM_RegWrite → fwd_A = 01. Set DX_rs = 0 → fwd_A = 00. Preload stall_cnt to all-ones plus a further stall → value holds at all-ones.
